// File: rtl/snapshot_mem_bridge.sv
// Register-bus to wide-memory bridge: a snapshot register holds PARTITION_CNT bus-width
// slices of one memory word so wide reads and writes are atomic.
module snapshot_mem_bridge #(
  parameter int                        BUS_DATA_WIDTH  = 32,
  parameter int                        BUS_ADDR_WIDTH  = 64,
  parameter int                        MEM_DATA_WIDTH  = 128,
  parameter int                        MEM_ADDR_WIDTH  = 32,
  parameter bit                        WR_TRIGGER_LAST = 1'b1,
  parameter int                        TIMEOUT_CYCLES  = 0,
  parameter logic [MEM_DATA_WIDTH-1:0] RST_VALUE       = '0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_soft_rst,
  input  logic                      i_req_vld,
  input  logic                      i_wr_en,
  input  logic                      i_rd_en,
  input  logic [BUS_ADDR_WIDTH-1:0] i_addr,
  input  logic [BUS_DATA_WIDTH-1:0] i_wr_data,
  output logic                      o_ack_vld,
  output logic                      o_err,
  output logic [BUS_DATA_WIDTH-1:0] o_rd_data,
  output logic                      o_mem_req_vld,
  input  logic                      i_mem_ack_vld,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
  output logic                      o_mem_wr_en,
  output logic                      o_mem_rd_en,
  output logic [MEM_DATA_WIDTH-1:0] o_mem_wr_data,
  input  logic [MEM_DATA_WIDTH-1:0] i_mem_rd_data
);
  localparam int PCNT = MEM_DATA_WIDTH / BUS_DATA_WIDTH;
  localparam int LSB  = $clog2(BUS_DATA_WIDTH / 8);
  localparam int OFF  = $clog2(MEM_DATA_WIDTH / 8);
  localparam int PW   = (PCNT > 1) ? $clog2(PCNT) : 1;
  localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] TRIG = WR_TRIGGER_LAST ? PW'(PCNT - 1) : '0;
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} state_t;

  state_t                    r_state;
  logic [MEM_DATA_WIDTH-1:0] r_snap;
  logic [TW-1:0]             r_tcnt;

  logic [PW-1:0]             w_p;
  logic [MEM_ADDR_WIDTH-1:0] w_waddr;
  logic [MEM_DATA_WIDTH-1:0] w_merged;
  logic [BUS_DATA_WIDTH-1:0] w_rd_part;
  logic                      w_accept;
  logic                      w_timeout;
  logic                      w_unused;

  generate
    if (PCNT > 1) begin : g_part
      assign w_p = i_addr[OFF-1:LSB];
    end else begin : g_single
      assign w_p = '0;
    end
  endgenerate

  assign w_waddr  = i_addr[OFF +: MEM_ADDR_WIDTH];
  assign w_unused = ^i_addr;

  always_comb begin
    w_merged = r_snap;
    w_merged[w_p*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = i_wr_data;
    w_rd_part = r_snap[w_p*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
  end

  // RESP accepts like IDLE so back-to-back requests lose no cycle.
  assign w_accept  = (r_state != S_MEM) && i_req_vld && (i_wr_en || i_rd_en);
  assign w_timeout = (TIMEOUT_CYCLES > 0) && (r_tcnt == TLIM);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_snap        <= RST_VALUE;
      r_tcnt        <= '0;
      o_ack_vld     <= 1'b0;
      o_err         <= 1'b0;
      o_rd_data     <= '0;
      o_mem_req_vld <= 1'b0;
      o_mem_wr_en   <= 1'b0;
      o_mem_rd_en   <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wr_data <= '0;
    end else if (i_soft_rst) begin
      r_state       <= S_IDLE;
      r_tcnt        <= '0;
      o_ack_vld     <= 1'b0;
      o_err         <= 1'b0;
      o_mem_req_vld <= 1'b0;
      o_mem_wr_en   <= 1'b0;
      o_mem_rd_en   <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wr_data <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_RESP: begin
          r_state   <= S_IDLE;
          o_ack_vld <= 1'b0;
          o_err     <= 1'b0;
          if (w_accept) begin
            if (i_wr_en && i_rd_en) begin
              r_state   <= S_RESP;
              o_ack_vld <= 1'b1;
              o_err     <= 1'b1;
            end else if (i_rd_en) begin
              if (w_p == '0) begin
                r_state       <= S_MEM;
                o_mem_req_vld <= 1'b1;
                o_mem_rd_en   <= 1'b1;
                o_mem_addr    <= w_waddr;
              end else begin
                r_state   <= S_RESP;
                o_ack_vld <= 1'b1;
                o_rd_data <= w_rd_part;
              end
            end else begin
              r_snap <= w_merged;
              if (w_p == TRIG) begin
                r_state       <= S_MEM;
                o_mem_req_vld <= 1'b1;
                o_mem_wr_en   <= 1'b1;
                o_mem_addr    <= w_waddr;
                o_mem_wr_data <= w_merged;
              end else begin
                r_state   <= S_RESP;
                o_ack_vld <= 1'b1;
              end
            end
          end
        end
        S_MEM: begin
          if (i_mem_ack_vld || w_timeout) begin
            r_state       <= S_RESP;
            r_tcnt        <= '0;
            o_ack_vld     <= 1'b1;
            o_mem_req_vld <= 1'b0;
            o_mem_wr_en   <= 1'b0;
            o_mem_rd_en   <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_wr_data <= '0;
            // A real ack beats a timeout landing in the same cycle.
            if (i_mem_ack_vld) begin
              o_err <= 1'b0;
              if (o_mem_rd_en) begin
                r_snap    <= i_mem_rd_data;
                o_rd_data <= i_mem_rd_data[BUS_DATA_WIDTH-1:0];
              end
            end else begin
              o_err     <= 1'b1;
              o_rd_data <= '0;
            end
          end else if (TIMEOUT_CYCLES > 0) begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
